// File: rtl/pong_score_keeper.sv
// Pong game-flow controller: turns ball-miss pulses into scores and sequences
// serve / play / point pause / game over, gating ball motion through ball_en.
module pong_score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic       clk_pix,
    input  logic       rst_pix_n,
    input  logic       frame,
    input  logic       new_game,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       ball_en,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] dbg_state
);

    localparam int         CW       = $clog2(PAUSE_FRAMES + 1);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_FRAMES - 1);

    // Encoding is visible on dbg_state: 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [3:0]    score_l_q, score_l_n;
    logic [3:0]    score_r_q, score_r_n;
    logic          serve_dir_q, serve_dir_n;
    logic          winner_q, winner_n;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            score_l_q   <= score_l_n;
            score_r_q   <= score_r_n;
            serve_dir_q <= serve_dir_n;
            winner_q    <= winner_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        score_l_n   = score_l_q;
        score_r_n   = score_r_q;
        serve_dir_n = serve_dir_q;
        winner_n    = winner_q;

        // new_game restarts from any state and overrides a same-cycle miss or frame.
        if (new_game) begin
            state_n   = SERVE;
            cnt_n     = '0;
            score_l_n = '0;
            score_r_n = '0;
        end else begin
            case (state_q)
                SERVE: begin
                    if (frame) begin
                        if (cnt_q == CNT_LAST) begin
                            state_n = PLAY;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (miss_l) begin
                        if (score_r_q < WIN) score_r_n = score_r_q + 4'd1;
                        serve_dir_n = 1'b0;
                        state_n     = POINT;
                    end else if (miss_r) begin
                        if (score_l_q < WIN) score_l_n = score_l_q + 4'd1;
                        serve_dir_n = 1'b1;
                        state_n     = POINT;
                    end
                end
                POINT: begin
                    if (frame) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_n = '0;
                            if (score_l_q == WIN || score_r_q == WIN) begin
                                state_n  = OVER;
                                winner_n = (score_r_q == WIN);
                            end else begin
                                state_n = SERVE;
                            end
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign ball_en   = (state_q == PLAY);
    assign game_over = (state_q == OVER);
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed game scenarios followed by random pulse
// traffic, all checked every cycle against a points/pause-countdown game model.
module tb_pong_score_keeper;

    localparam int WIN = 3;
    localparam int PF  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_POINT = 3;
    localparam int M_OVER  = 4;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n = 1'b0;
    logic       frame = 1'b0;
    logic       new_game = 1'b0;
    logic       miss_l = 1'b0;
    logic       miss_r = 1'b0;
    logic [3:0] score_l, score_r;
    logic       ball_en, serve_dir, game_over, winner;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // game model: points per side (0 left, 1 right) and frames left in the pause
    int m_mode;
    int m_pts[2];
    int m_left;
    int m_dir;
    int m_win;

    pong_score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .frame     (frame),
        .new_game  (new_game),
        .miss_l    (miss_l),
        .miss_r    (miss_r),
        .score_l   (score_l),
        .score_r   (score_r),
        .ball_en   (ball_en),
        .serve_dir (serve_dir),
        .game_over (game_over),
        .winner    (winner),
        .dbg_state (dbg_state)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic award(input int side);
        m_pts[side] = (m_pts[side] + 1 > WIN) ? WIN : m_pts[side] + 1;
    endtask

    task automatic model_update(input bit r, input bit ng, input bit fr, input bit ml, input bit mr);
        if (!r) begin
            m_mode = M_IDLE; m_pts[0] = 0; m_pts[1] = 0; m_left = PF; m_dir = 0; m_win = 0;
        end else if (ng) begin
            m_mode = M_SERVE; m_pts[0] = 0; m_pts[1] = 0; m_left = PF;
        end else if (m_mode == M_SERVE) begin
            if (fr) begin
                m_left--;
                if (m_left == 0) begin m_mode = M_PLAY; m_left = PF; end
            end
        end else if (m_mode == M_PLAY) begin
            if (ml) begin award(1); m_dir = 0; m_mode = M_POINT; end
            else if (mr) begin award(0); m_dir = 1; m_mode = M_POINT; end
        end else if (m_mode == M_POINT) begin
            if (fr) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = PF;
                    if (m_pts[0] == WIN || m_pts[1] == WIN) begin
                        m_mode = M_OVER;
                        m_win  = (m_pts[1] == WIN) ? 1 : 0;
                    end else begin
                        m_mode = M_SERVE;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("score_l", 32'(score_l), 32'(m_pts[0]));
        chk("score_r", 32'(score_r), 32'(m_pts[1]));
        chk("ball_en", 32'(ball_en), 32'(m_mode == M_PLAY));
        chk("game_over", 32'(game_over), 32'(m_mode == M_OVER));
        chk("serve_dir", 32'(serve_dir), 32'(m_dir));
        chk("state", 32'(dbg_state), 32'(m_mode));
        if (m_mode == M_OVER) chk("winner", 32'(winner), 32'(m_win));
    endtask

    // one clock: drive inputs, let the edge sample them, then compare at the falling edge
    task automatic step(input bit r, input bit ng, input bit fr, input bit ml, input bit mr);
        rst_pix_n = r; new_game = ng; frame = fr; miss_l = ml; miss_r = mr;
        @(posedge clk_pix);
        model_update(r, ng, fr, ml, mr);
        @(negedge clk_pix);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic two_frames();
        step(1, 0, 1, 0, 0); idle(2);
        step(1, 0, 1, 0, 0); idle(1);
    endtask

    initial begin
        @(negedge clk_pix);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);

        // reset then long idle; frames and misses in IDLE do nothing
        idle(100);
        step(1, 0, 1, 1, 1);
        chk("idle_state", 32'(dbg_state), 32'(M_IDLE));

        // new_game then two frames to reach PLAY
        step(1, 1, 0, 0, 0);
        two_frames();
        chk("play_ball_en", 32'(ball_en), 32'd1);

        // right-edge miss scores for left, serves rightwards
        step(1, 0, 0, 0, 1);
        chk("miss_r_score_l", 32'(score_l), 32'd1);
        chk("miss_r_dir", 32'(serve_dir), 32'd1);
        two_frames();
        two_frames();

        // simultaneous misses: left miss wins
        step(1, 0, 0, 1, 1);
        chk("both_score_r", 32'(score_r), 32'd1);
        chk("both_score_l", 32'(score_l), 32'd1);
        two_frames();
        two_frames();

        // two more right points end the game with the right player ahead
        for (int p = 0; p < 2; p++) begin
            step(1, 0, 0, 1, 0);
            two_frames();
            if (p == 0) two_frames();
        end
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_winner", 32'(winner), 32'd1);
        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1);
        chk("over_hold_r", 32'(score_r), 32'd3);
        step(1, 1, 0, 0, 0);
        chk("restart_over", 32'(game_over), 32'd0);

        // reach POINT at 2/1, then reset in the middle of the pause
        two_frames();
        step(1, 0, 0, 0, 1); two_frames(); two_frames();
        step(1, 0, 0, 0, 1); two_frames(); two_frames();
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_point_state", 32'(dbg_state), 32'(M_IDLE));

        // new_game at pause count 1 needs a full fresh pause
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("restart_pause", 32'(ball_en), 32'd0);
        step(1, 0, 1, 0, 0);
        chk("restart_play", 32'(ball_en), 32'd1);

        // random pulse traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
